// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 multi-channel convolution with line buffers and double-buffered weights
//
// Purpose: consumes raster pixels of NCH unsigned channels and emits NOUT signed
// convolution results for every fully-populated 3x3 window ((IMG_W-2)x(IMG_H-2)
// results per frame). The pipeline has two stages (window register, MAC + ReLU)
// and stalls as a whole on output backpressure.
//
// Ports:
//   clk, RESET        clock, synchronous active-high reset
//   s_valid/s_ready   input pixel handshake
//   s_sof             marks pixel (row 0, col 0) of a frame
//   s_data            NCH*DATA_W input pixel, channel c at [c*DATA_W +: DATA_W]
//   m_valid/m_ready   output result handshake
//   m_sof, m_eol      first result of frame / last result of output line
//   m_data            NOUT*ACC_W results, kernel o at [o*ACC_W +: ACC_W]
//   w_we/w_addr/w_data shadow weight write, index (o*NCH+c)*9 + 3*ky + kx
//   relu_en           clamp negative results to zero
//   resync            one-cycle pulse when s_sof arrives with counters not at (0,0)
module conv3x3_stream #(
  parameter int DATA_W = 8,
  parameter int NCH    = 3,
  parameter int NOUT   = 3,
  parameter int W_W    = 8,
  parameter int ACC_W  = 21,
  parameter int IMG_W  = 1920,
  parameter int IMG_H  = 1080,
  localparam int NW    = NOUT*NCH*9,
  localparam int AW    = $clog2(NW)
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_sof,
  input  logic [NCH*DATA_W-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_sof,
  output logic                    m_eol,
  output logic [NOUT*ACC_W-1:0]   m_data,
  input  logic                    w_we,
  input  logic [AW-1:0]           w_addr,
  input  logic [W_W-1:0]          w_data,
  input  logic                    relu_en,
  output logic                    resync
);

  localparam int PW = NCH*DATA_W;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          en;
  logic          accept;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] ec;
  logic [RW-1:0] er;

  // lb0 holds line row-2, lb1 holds line row-1, both indexed by column
  logic [PW-1:0] lb0 [IMG_W];
  logic [PW-1:0] lb1 [IMG_W];

  // Stage 1: window[ky][kx], ky=0 oldest line, kx=0 oldest column
  logic [PW-1:0] win [3][3];
  logic          s1_valid;
  logic          s1_sof;
  logic          s1_eol;

  logic signed [W_W-1:0] w_act [NW];
  logic signed [W_W-1:0] w_sh  [NW];

  logic [NOUT*ACC_W-1:0] acc_data;

  assign en      = !m_valid || m_ready;
  assign s_ready = en && !RESET;
  assign accept  = s_valid && s_ready;

  // s_sof forces the accepted pixel to position (0,0) regardless of counters
  assign ec = s_sof ? '0 : col;
  assign er = s_sof ? '0 : row;

  // Line buffers are never read before row 2 of a frame, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[ec] <= lb1[ec];
      lb1[ec] <= s_data;
    end
  end

  // Stage 2 arithmetic: pixels are zero-extended to signed before multiply
  always_comb begin
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] px;
    logic signed [ACC_W-1:0] wx;
    acc_data = '0;
    sum      = '0;
    px       = '0;
    wx       = '0;
    for (int o = 0; o < NOUT; o++) begin
      sum = '0;
      for (int c = 0; c < NCH; c++) begin
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            px  = ACC_W'($signed({1'b0, win[ky][kx][c*DATA_W +: DATA_W]}));
            wx  = ACC_W'(w_act[(o*NCH+c)*9 + 3*ky + kx]);
            sum = sum + px * wx;
          end
        end
      end
      if (relu_en && sum[ACC_W-1]) sum = '0;
      acc_data[o*ACC_W +: ACC_W] = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      row      <= '0;
      col      <= '0;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      m_valid  <= 1'b0;
      m_sof    <= 1'b0;
      m_eol    <= 1'b0;
      m_data   <= '0;
      resync   <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        w_act[i] <= W_W'(1);
        w_sh[i]  <= W_W'(1);
      end
      for (int ky = 0; ky < 3; ky++) begin
        for (int kx = 0; kx < 3; kx++) begin
          win[ky][kx] <= '0;
        end
      end
    end else begin
      resync <= 1'b0;

      // Shadow write; a write coinciding with s_sof lands after the copy below
      if (w_we && (int'(w_addr) < NW)) w_sh[w_addr] <= w_data;

      if (accept) begin
        if (ec == CW'(IMG_W-1)) begin
          col <= '0;
          row <= (er == RW'(IMG_H-1)) ? '0 : er + 1'b1;
        end else begin
          col <= ec + 1'b1;
          row <= er;
        end

        for (int ky = 0; ky < 3; ky++) begin
          win[ky][0] <= win[ky][1];
          win[ky][1] <= win[ky][2];
        end
        win[0][2] <= lb0[ec];
        win[1][2] <= lb1[ec];
        win[2][2] <= s_data;

        if (s_sof) begin
          for (int i = 0; i < NW; i++) w_act[i] <= w_sh[i];
          if ((row != '0) || (col != '0)) resync <= 1'b1;
        end
      end

      if (en) begin
        s1_valid <= accept && (er >= RW'(2)) && (ec >= CW'(2));
        s1_sof   <= (er == RW'(2)) && (ec == CW'(2));
        s1_eol   <= (ec == CW'(IMG_W-1));
        if (s1_valid) begin
          m_valid <= 1'b1;
          m_sof   <= s1_sof;
          m_eol   <= s1_eol;
          m_data  <= acc_data;
        end else begin
          m_valid <= 1'b0;
          m_sof   <= 1'b0;
          m_eol   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - self-checking bench for conv3x3_stream against a window-sum reference model
module tb_conv3x3_stream;

  localparam int DATA_W = 8;
  localparam int NCH    = 3;
  localparam int NOUT   = 3;
  localparam int W_W    = 8;
  localparam int ACC_W  = 21;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 4;
  localparam int NW     = NOUT*NCH*9;
  localparam int AW     = $clog2(NW);
  localparam int DW     = NOUT*ACC_W;

  logic                  clk = 1'b0;
  logic                  RESET;
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_sof;
  logic [NCH*DATA_W-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_sof;
  logic                  m_eol;
  logic [DW-1:0]         m_data;
  logic                  w_we;
  logic [AW-1:0]         w_addr;
  logic [W_W-1:0]        w_data;
  logic                  relu_en;
  logic                  resync;

  always #5 clk = ~clk;

  conv3x3_stream #(
    .DATA_W(DATA_W), .NCH(NCH), .NOUT(NOUT), .W_W(W_W),
    .ACC_W(ACC_W), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .RESET(RESET),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .m_data(m_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .relu_en(relu_en), .resync(resync)
  );

  typedef struct {
    logic [DW-1:0] d;
    bit            sof;
    bit            eol;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   rmode  = 0;   // 0: m_ready=1, 1: random, 2: m_ready=0
  int   resync_cnt = 0;
  bit   done = 0;

  // Reference model state
  int   mrow = 0;
  int   mcol = 0;
  int   mimg [IMG_H][IMG_W][NCH];
  int   mact [NW];
  int   msh  [NW];
  res_t expq [$];
  res_t logq [$];
  bit   exp_resync = 0;
  bit   prev_stall = 0;
  res_t prev_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Direct 3x3xNCH dot product over the stored frame image
  function automatic logic [DW-1:0] model_out(input int r, input int c);
    logic [DW-1:0]    res;
    logic [ACC_W-1:0] t;
    int               s;
    res = '0;
    for (int o = 0; o < NOUT; o++) begin
      s = 0;
      for (int ch = 0; ch < NCH; ch++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            s += mimg[r-2+ky][c-2+kx][ch] * mact[(o*NCH+ch)*9 + 3*ky + kx];
      if (relu_en && s < 0) s = 0;
      t = ACC_W'(s);
      res[o*ACC_W +: ACC_W] = t;
    end
    return res;
  endfunction

  initial begin
    for (int i = 0; i < NW; i++) begin
      mact[i] = 1;
      msh[i]  = 1;
    end
  end

  // Model update and output comparison, away from the active edge
  always @(negedge clk) begin
    res_t e;
    res_t g;
    if (resync === 1'b1) resync_cnt++;
    if (RESET) begin
      chk("s_ready_in_reset", 64'(s_ready), 64'(0));
      expq.delete();
      mrow = 0;
      mcol = 0;
      for (int i = 0; i < NW; i++) begin
        mact[i] = 1;
        msh[i]  = 1;
      end
      exp_resync = 0;
      prev_stall = 0;
    end else begin
      chk("s_ready_rule", 64'(s_ready), 64'(!(m_valid && !m_ready)));
      chk("resync", 64'(resync), 64'(exp_resync));
      if (prev_stall) begin
        chk("hold_valid", 64'(m_valid), 64'(1));
        chk("hold_data", 64'(m_data), 64'(prev_out.d));
        chk("hold_flags", 64'({m_sof, m_eol}), 64'({prev_out.sof, prev_out.eol}));
      end
      if (m_valid && m_ready) begin
        g.d = m_data; g.sof = m_sof; g.eol = m_eol;
        logq.push_back(g);
        if (expq.size() == 0) begin
          chk("unexpected_output", 64'(1), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("m_data", 64'(m_data), 64'(e.d));
          chk("m_sof", 64'(m_sof), 64'(e.sof));
          chk("m_eol", 64'(m_eol), 64'(e.eol));
        end
      end
      prev_stall   = m_valid && !m_ready;
      prev_out.d   = m_data;
      prev_out.sof = m_sof;
      prev_out.eol = m_eol;

      exp_resync = 0;
      if (s_valid && s_ready) begin
        if (s_sof) begin
          if (mrow != 0 || mcol != 0) exp_resync = 1;
          mrow = 0;
          mcol = 0;
          mact = msh;
        end
        for (int ch = 0; ch < NCH; ch++) mimg[mrow][mcol][ch] = int'(s_data[ch*DATA_W +: DATA_W]);
        if (mrow >= 2 && mcol >= 2) begin
          e.d   = model_out(mrow, mcol);
          e.sof = (mrow == 2 && mcol == 2);
          e.eol = (mcol == IMG_W-1);
          expq.push_back(e);
        end
        mcol++;
        if (mcol == IMG_W) begin
          mcol = 0;
          mrow = (mrow == IMG_H-1) ? 0 : mrow + 1;
        end
      end
      if (w_we) msh[w_addr] = int'($signed(w_data));
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [NCH*DATA_W-1:0] pgen(input int mode, input int c);
    case (mode)
      0:       return {NCH{8'h01}};
      1:       return (NCH*DATA_W)'(c);
      default: return (NCH*DATA_W)'($urandom);
    endcase
  endfunction

  task automatic send_px(input logic [NCH*DATA_W-1:0] d, input bit sof, input int gap);
    bit got;
    int n;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    got = 0;
    n   = 0;
    while (!got && n < 500) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("input_accept_timeout", 64'(0), 64'(1));
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic write_w(input int a, input int v);
    w_we   = 1'b1;
    w_addr = AW'(a);
    w_data = W_W'(v);
    @(posedge clk);
    #1;
    w_we   = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int maxgap, input int stop_at, input int wr_at);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (r*IMG_W + c == stop_at) return;
        send_px(pgen(mode, c), (r == 0 && c == 0), $urandom_range(0, maxgap));
        if (r*IMG_W + c == wr_at)
          for (int k = 0; k < NCH*9; k++) write_w(k, -1);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", 64'(expq.size()), 64'(0));
  endtask

  task automatic check_log(input string nm, input int n, input int k0, input int ko);
    logic [ACC_W-1:0] e;
    chk({nm, "_count"}, 64'(logq.size()), 64'(n));
    if (logq.size() == n) begin
      for (int i = 0; i < n; i++) begin
        for (int o = 0; o < NOUT; o++) begin
          e = ACC_W'((o == 0) ? k0 : ko);
          chk(nm, 64'(logq[i].d[o*ACC_W +: ACC_W]), 64'(e));
        end
      end
    end
  endtask

  initial begin
    logic [ACC_W-1:0] e;
    RESET   = 1'b1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = '0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    relu_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_flags", 64'({m_sof, m_eol, resync}), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    @(posedge clk);
    #1;
    RESET = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;

    // All-ones frame with box weights
    logq.delete();
    send_frame(0, 0, -1, -1);
    drain();
    check_log("ones", 6, 27, 27);
    if (logq.size() == 6) begin
      chk("ones_sof", 64'({logq[0].sof, logq[1].sof, logq[3].sof}), 64'(3'b100));
      chk("ones_eol", 64'({logq[1].eol, logq[2].eol, logq[4].eol, logq[5].eol}), 64'(4'b0101));
    end

    // Column ramp on channel 0, then again under random backpressure
    for (int pass = 0; pass < 2; pass++) begin
      rmode = pass;
      logq.delete();
      send_frame(1, pass, -1, -1);
      drain();
      chk("ramp_count", 64'(logq.size()), 64'(6));
      if (logq.size() == 6)
        for (int i = 0; i < 6; i++) begin
          e = ACC_W'(9 * (i % 3 + 1));
          chk("ramp_val", 64'(logq[i].d[0 +: ACC_W]), 64'(e));
        end
    end

    // Random data under random backpressure
    rmode = 1;
    for (int f = 0; f < 3; f++) send_frame(2, 2, -1, -1);
    drain();
    rmode = 0;

    // Mid-frame weight write must not touch the running frame
    logq.delete();
    send_frame(0, 0, -1, 7);
    drain();
    check_log("midw_cur", 6, 27, 27);
    logq.delete();
    send_frame(0, 0, -1, -1);
    drain();
    check_log("midw_next", 6, -27, 27);

    relu_en = 1'b1;
    logq.delete();
    send_frame(0, 0, -1, -1);
    drain();
    check_log("relu", 6, 0, 27);

    // Random weights, random relu, random data and backpressure
    for (int k = 0; k < NW; k++) write_w(k, $urandom_range(0, 255));
    relu_en = 1'($urandom_range(0, 1));
    rmode = 1;
    for (int f = 0; f < 2; f++) send_frame(2, 1, -1, -1);
    drain();
    relu_en = 1'b0;
    rmode = 0;

    // s_sof arriving with counters at row 2 col 3
    resync_cnt = 0;
    send_frame(2, 0, 13, -1);
    send_frame(2, 0, -1, -1);
    drain();
    chk("resync_count", 64'(resync_cnt), 64'(1));

    // Reset while a result is held by backpressure
    rmode = 2;
    send_frame(2, 0, 13, -1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("held_before_reset", 64'(m_valid), 64'(1));
    @(posedge clk);
    #1;
    RESET = 1'b1;
    @(posedge clk);
    #1;
    RESET = 1'b0;
    rmode = 0;
    @(negedge clk);
    chk("m_valid_after_reset", 64'(m_valid), 64'(0));
    @(posedge clk);
    #1;
    logq.delete();
    send_frame(0, 0, -1, -1);
    drain();
    check_log("after_reset", 6, 27, 27);

    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    if (!done) begin
      errors++;
      $display("FAIL watchdog actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

endmodule
